// File: rtl/medac_sweep_ctrl.sv
// medac_sweep_ctrl
// Calibration sequencer for the MEDAC-protected async FIFO test top. It runs
// in the write-clock domain and steps the variable-clock select code from
// sel_min to sel_max. For each code it settles, snapshots the MEDAC error
// counters, enables traffic through `start`, and drains. It then scores the
// error delta and keeps the code with the fewest errors. Ties keep the
// lower code.
//
// Optional feature: define MEDAC_SWEEP_LOG_EN to get a per-code result pulse
// on meas_valid/meas_sel/meas_err. Without the macro those outputs are tied
// to 0 and no logging registers exist.
module medac_sweep_ctrl #(
   parameter int CNT_W      = 32,
   parameter int MEAS_CYC   = 1024,
   parameter int SETTLE_CYC = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             go,
   input  logic             abort,
   input  logic [3:0]       sel_min,
   input  logic [3:0]       sel_max,
   input  logic [3:0]       win_sel_in,
   input  logic [CNT_W-1:0] error_origin_cnt,
   input  logic [CNT_W-1:0] error_ptr_cnt,
   output logic             start,
   output logic [3:0]       var_clk_sel_origin,
   output logic [3:0]       var_clk_sel_leading,
   output logic [3:0]       var_clk_sel_lagging,
   output logic [3:0]       win_sel,
   output logic             busy,
   output logic             done,
   output logic             best_valid,
   output logic [3:0]       best_sel,
   output logic [CNT_W-1:0] best_err,
   output logic             meas_valid,
   output logic [3:0]       meas_sel,
   output logic [CNT_W-1:0] meas_err
);

   // One down-counter serves the settle, measure and drain phases. It is
   // sized for the longer of the two phase lengths.
   localparam int TMAX = (MEAS_CYC > SETTLE_CYC) ? MEAS_CYC : SETTLE_CYC;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [TW-1:0]    SETTLE_LD = TW'(SETTLE_CYC - 1);
   localparam logic [TW-1:0]    MEAS_LD   = TW'(MEAS_CYC - 1);
   localparam logic [CNT_W-1:0] ALL_ONES  = '1;

   typedef enum logic [2:0] {
      S_IDLE, S_SETTLE, S_SNAP, S_MEAS, S_DRAIN, S_EVAL, S_NEXT, S_FIN
   } state_t;

   state_t           r_state;
   logic [TW-1:0]    r_tmr;
   logic [3:0]       r_k;
   logic [3:0]       r_lead;
   logic [3:0]       r_lag;
   logic [3:0]       r_max;
   logic [3:0]       r_win;
   logic             r_empty;
   logic             r_start;
   logic             r_busy;
   logic             r_done;
   logic             r_best_valid;
   logic [3:0]       r_best_sel;
   logic [CNT_W-1:0] r_best_err;
   logic [CNT_W-1:0] r_base_o;
   logic [CNT_W-1:0] r_base_p;

   logic [CNT_W-1:0] w_d_o;
   logic [CNT_W-1:0] w_d_p;
   logic [CNT_W:0]   w_sum_wide;
   logic [CNT_W-1:0] w_sum;
   logic [3:0]       w_k_inc;

   // Neighbouring codes, clamped to the 0..15 code range.
   function automatic logic [3:0] lead_of(input logic [3:0] k);
      return (k == 4'd15) ? 4'd15 : k + 4'd1;
   endfunction

   function automatic logic [3:0] lag_of(input logic [3:0] k);
      return (k == 4'd0) ? 4'd0 : k - 4'd1;
   endfunction

   // Per-code score. The subtraction is modular so a counter that wraps
   // during the window still gives the true delta. The sum saturates.
   always_comb begin
      w_d_o      = error_origin_cnt - r_base_o;
      w_d_p      = error_ptr_cnt - r_base_p;
      w_sum_wide = {1'b0, w_d_o} + {1'b0, w_d_p};
      w_sum      = w_sum_wide[CNT_W] ? ALL_ONES : w_sum_wide[CNT_W-1:0];
      w_k_inc    = r_k + 4'd1;
   end

   // Sweep sequencer. Every output is registered, and abort overrides any
   // transition out of a non-idle state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_tmr        <= '0;
         r_k          <= '0;
         r_lead       <= '0;
         r_lag        <= '0;
         r_max        <= '0;
         r_win        <= '0;
         r_empty      <= 1'b0;
         r_start      <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_best_valid <= 1'b0;
         r_best_sel   <= '0;
         r_best_err   <= ALL_ONES;
         r_base_o     <= '0;
         r_base_p     <= '0;
      end else begin
         r_done <= 1'b0;
         if (abort && (r_state != S_IDLE)) begin
            // The select outputs intentionally keep their last values.
            r_state      <= S_IDLE;
            r_start      <= 1'b0;
            r_busy       <= 1'b0;
            r_best_valid <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (go) begin
                     r_k          <= sel_min;
                     r_lead       <= lead_of(sel_min);
                     r_lag        <= lag_of(sel_min);
                     r_max        <= sel_max;
                     r_win        <= win_sel_in;
                     r_empty      <= (sel_min > sel_max);
                     r_best_err   <= ALL_ONES;
                     r_best_sel   <= sel_min;
                     r_best_valid <= 1'b0;
                     r_busy       <= 1'b1;
                     r_tmr        <= SETTLE_LD;
                     r_state      <= (sel_min > sel_max) ? S_FIN : S_SETTLE;
                  end
               end
               S_SETTLE: begin
                  if (r_tmr == '0) r_state <= S_SNAP;
                  else             r_tmr   <= r_tmr - 1'b1;
               end
               S_SNAP: begin
                  r_base_o <= error_origin_cnt;
                  r_base_p <= error_ptr_cnt;
                  r_tmr    <= MEAS_LD;
                  r_start  <= 1'b1;
                  r_state  <= S_MEAS;
               end
               S_MEAS: begin
                  if (r_tmr == '0) begin
                     r_start <= 1'b0;
                     r_tmr   <= SETTLE_LD;
                     r_state <= S_DRAIN;
                  end else begin
                     r_tmr <= r_tmr - 1'b1;
                  end
               end
               S_DRAIN: begin
                  if (r_tmr == '0) r_state <= S_EVAL;
                  else             r_tmr   <= r_tmr - 1'b1;
               end
               S_EVAL: begin
                  // A strict compare means an equal score never displaces
                  // the earlier, lower code.
                  if (w_sum < r_best_err) begin
                     r_best_err <= w_sum;
                     r_best_sel <= r_k;
                  end
                  r_state <= S_NEXT;
               end
               S_NEXT: begin
                  if (r_k == r_max) begin
                     r_state <= S_FIN;
                  end else begin
                     r_k     <= w_k_inc;
                     r_lead  <= lead_of(w_k_inc);
                     r_lag   <= lag_of(w_k_inc);
                     r_tmr   <= SETTLE_LD;
                     r_state <= S_SETTLE;
                  end
               end
               S_FIN: begin
                  r_done       <= 1'b1;
                  r_best_valid <= !r_empty;
                  r_busy       <= 1'b0;
                  r_state      <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign start               = r_start;
   assign var_clk_sel_origin  = r_k;
   assign var_clk_sel_leading = r_lead;
   assign var_clk_sel_lagging = r_lag;
   assign win_sel             = r_win;
   assign busy                = r_busy;
   assign done                = r_done;
   assign best_valid          = r_best_valid;
   assign best_sel            = r_best_sel;
   assign best_err            = r_best_err;

`ifdef MEDAC_SWEEP_LOG_EN
   logic             r_meas_valid;
   logic [3:0]       r_meas_sel;
   logic [CNT_W-1:0] r_meas_err;

   // Per-code result log. It is valid in the cycle after EVAL, which
   // coincides with NEXT.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_meas_valid <= 1'b0;
         r_meas_sel   <= '0;
         r_meas_err   <= '0;
      end else begin
         r_meas_valid <= (r_state == S_EVAL) && !abort;
         if ((r_state == S_EVAL) && !abort) begin
            r_meas_sel <= r_k;
            r_meas_err <= w_sum;
         end
      end
   end

   assign meas_valid = r_meas_valid;
   assign meas_sel   = r_meas_sel;
   assign meas_err   = r_meas_err;
`else
   assign meas_valid = 1'b0;
   assign meas_sel   = 4'd0;
   assign meas_err   = '0;
`endif

endmodule

// File: tb/tb_medac_sweep_ctrl.sv
// tb_medac_sweep_ctrl
// Directed bench for medac_sweep_ctrl with MEAS_CYC=8 and SETTLE_CYC=2, which
// gives 15 cycles per code. Error injection is table driven: when `start`
// rises, the counters jump by the amounts listed for the current code.
module tb_medac_sweep_ctrl;

   localparam int CNT_W = 32;
   localparam logic [31:0] ONES = 32'hFFFF_FFFF;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             go = 1'b0;
   logic             abort = 1'b0;
   logic [3:0]       sel_min = '0;
   logic [3:0]       sel_max = '0;
   logic [3:0]       win_sel_in = '0;
   logic [CNT_W-1:0] error_origin_cnt = '0;
   logic [CNT_W-1:0] error_ptr_cnt = '0;
   logic             start;
   logic [3:0]       var_clk_sel_origin;
   logic [3:0]       var_clk_sel_leading;
   logic [3:0]       var_clk_sel_lagging;
   logic [3:0]       win_sel;
   logic             busy;
   logic             done;
   logic             best_valid;
   logic [3:0]       best_sel;
   logic [CNT_W-1:0] best_err;
   logic             meas_valid;
   logic [3:0]       meas_sel;
   logic [CNT_W-1:0] meas_err;

   medac_sweep_ctrl #(
      .CNT_W     (CNT_W),
      .MEAS_CYC  (8),
      .SETTLE_CYC(2)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .go                 (go),
      .abort              (abort),
      .sel_min            (sel_min),
      .sel_max            (sel_max),
      .win_sel_in         (win_sel_in),
      .error_origin_cnt   (error_origin_cnt),
      .error_ptr_cnt      (error_ptr_cnt),
      .start              (start),
      .var_clk_sel_origin (var_clk_sel_origin),
      .var_clk_sel_leading(var_clk_sel_leading),
      .var_clk_sel_lagging(var_clk_sel_lagging),
      .win_sel            (win_sel),
      .busy               (busy),
      .done               (done),
      .best_valid         (best_valid),
      .best_sel           (best_sel),
      .best_err           (best_err),
      .meas_valid         (meas_valid),
      .meas_sel           (meas_sel),
      .meas_err           (meas_err)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] inj_o [16];
   logic [31:0] inj_p [16];
   int          start_cycles = 0;
   int          n_meas = 0;
   logic [3:0]  last_meas_sel = '0;
   logic [31:0] last_meas_err = '0;
   int          lat;
   int          cnt;

   task automatic check_val(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_inj();
      for (int i = 0; i < 16; i++) begin
         inj_o[i] = '0;
         inj_p[i] = '0;
      end
      start_cycles = 0;
      n_meas = 0;
   endtask

   // Drive a go pulse. On return it is the negedge of the first cycle
   // after go was sampled.
   task automatic do_go(input logic [3:0] mn, input logic [3:0] mx,
                        input logic [3:0] ws);
      @(negedge clk);
      sel_min = mn;
      sel_max = mx;
      win_sel_in = ws;
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
   endtask

   // Count cycles since go until done is seen. The count is bounded, so a
   // hang shows up as a latency error.
   task automatic wait_done(output int l);
      l = 1;
      while (!done && l < 300) begin
         @(negedge clk);
         l++;
      end
   endtask

   // Error injector and monitor. The counters jump on the first MEAS cycle.
   initial begin : injector
      logic prev_start;
      prev_start = 1'b0;
      forever begin
         @(negedge clk);
         if (start && !prev_start) begin
            error_origin_cnt = error_origin_cnt + inj_o[var_clk_sel_origin];
            error_ptr_cnt    = error_ptr_cnt + inj_p[var_clk_sel_origin];
         end
         if (start) start_cycles++;
         if (meas_valid) begin
            n_meas++;
            last_meas_sel = meas_sel;
            last_meas_err = meas_err;
         end
         prev_start = start;
      end
   end

   initial begin
      clear_inj();
      repeat (3) @(negedge clk);
      // Reset state.
      check_val("rst_start", start, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_best_valid", best_valid, 0);
      check_val("rst_best_err", best_err, ONES);
      check_val("rst_origin", var_clk_sel_origin, 0);
      rst = 1'b0;

      // Full sweep 3..7. Codes other than 5 see 4 pointer errors.
      clear_inj();
      for (int c = 3; c <= 7; c++) if (c != 5) inj_p[c] = 32'd4;
      do_go(4'd3, 4'd7, 4'hA);
      sel_min = 4'd0; sel_max = 4'd15; win_sel_in = 4'h0;
      check_val("full_busy_rise", busy, 1);
      check_val("full_origin3", var_clk_sel_origin, 3);
      check_val("full_lead3", var_clk_sel_leading, 4);
      check_val("full_lag3", var_clk_sel_lagging, 2);
      check_val("full_win_sel", win_sel, 4'hA);
      wait_done(lat);
      check_val("full_latency", lat, 77);
      check_val("full_busy_fall", busy, 0);
      @(negedge clk);
      check_val("full_best_sel", best_sel, 5);
      check_val("full_best_err", best_err, 0);
      check_val("full_best_valid", best_valid, 1);
      check_val("full_start_cycles", start_cycles, 40);
      check_val("done_one_cycle", done, 0);

      // Boundary code 0.
      clear_inj();
      do_go(4'd0, 4'd0, 4'h1);
      check_val("b0_lead", var_clk_sel_leading, 1);
      check_val("b0_lag", var_clk_sel_lagging, 0);
      wait_done(lat);
      check_val("b0_latency", lat, 17);

      // Boundary code 15.
      clear_inj();
      do_go(4'd15, 4'd15, 4'h2);
      check_val("b15_lead", var_clk_sel_leading, 15);
      check_val("b15_lag", var_clk_sel_lagging, 14);
      wait_done(lat);
      check_val("b15_latency", lat, 17);
      @(negedge clk);
      check_val("b15_best_sel", best_sel, 15);

      // Counter wrap. The origin counter goes 0xFFFF_FFFE -> 0x1.
      clear_inj();
      error_origin_cnt = 32'hFFFF_FFFE;
      inj_o[4] = 32'd3;
      do_go(4'd4, 4'd4, 4'h0);
      wait_done(lat);
      check_val("wrap_latency", lat, 17);
      @(negedge clk);
      check_val("wrap_best_err", best_err, 3);
      check_val("wrap_best_sel", best_sel, 4);
`ifdef MEDAC_SWEEP_LOG_EN
      check_val("wrap_meas_count", n_meas, 1);
      check_val("wrap_meas_err", last_meas_err, 3);
      check_val("wrap_meas_sel", last_meas_sel, 4);
`else
      check_val("nolog_meas_count", n_meas, 0);
`endif

      // Saturating sum: the result stays all ones and never beats the
      // initial best.
      clear_inj();
      inj_o[1] = 32'hFFFF_FFF0;
      inj_p[1] = 32'h0000_0020;
      do_go(4'd1, 4'd1, 4'h0);
      wait_done(lat);
      @(negedge clk);
      check_val("sat_best_err", best_err, ONES);
      check_val("sat_best_sel", best_sel, 1);
      check_val("sat_best_valid", best_valid, 1);

      // Tie between codes 2 and 3 keeps the lower code.
      clear_inj();
      inj_p[2] = 32'd1;
      inj_p[3] = 32'd1;
      do_go(4'd2, 4'd3, 4'h0);
      wait_done(lat);
      check_val("tie_latency", lat, 32);
      @(negedge clk);
      check_val("tie_best_sel", best_sel, 2);
      check_val("tie_best_err", best_err, 1);

      // Empty range.
      clear_inj();
      do_go(4'd9, 4'd4, 4'h0);
      wait_done(lat);
      check_val("empty_latency", lat, 2);
      @(negedge clk);
      check_val("empty_best_valid", best_valid, 0);
      check_val("empty_best_err", best_err, ONES);
      check_val("empty_best_sel", best_sel, 9);
      check_val("empty_start_cycles", start_cycles, 0);

      // Abort during MEAS of the second code.
      clear_inj();
      do_go(4'd0, 4'd3, 4'h0);
      cnt = 0;
      while (!(start && var_clk_sel_origin == 4'd1) && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      check_val("abort_reach_meas", cnt < 100, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_val("abort_start", start, 0);
      check_val("abort_busy", busy, 0);
      check_val("abort_best_valid", best_valid, 0);
      check_val("abort_origin_hold", var_clk_sel_origin, 1);
      check_val("abort_lead_hold", var_clk_sel_leading, 2);
      cnt = 0;
      for (int i = 0; i < 60; i++) begin
         if (done || start) cnt++;
         @(negedge clk);
      end
      check_val("abort_quiet", cnt, 0);

      // A normal sweep after the abort.
      clear_inj();
      inj_o[0] = 32'd2;
      do_go(4'd0, 4'd1, 4'h3);
      wait_done(lat);
      check_val("post_abort_latency", lat, 32);
      @(negedge clk);
      check_val("post_abort_best_sel", best_sel, 1);
      check_val("post_abort_best_err", best_err, 0);

      // Synchronous reset during SETTLE.
      clear_inj();
      do_go(4'd2, 4'd5, 4'h5);
      rst = 1'b1;
      @(negedge clk);
      check_val("srst_busy", busy, 0);
      check_val("srst_origin", var_clk_sel_origin, 0);
      check_val("srst_lead", var_clk_sel_leading, 0);
      check_val("srst_lag", var_clk_sel_lagging, 0);
      check_val("srst_win_sel", win_sel, 0);
      check_val("srst_best_sel", best_sel, 0);
      check_val("srst_best_err", best_err, ONES);
      check_val("srst_start", start, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
